// File: rtl/ysyx_22040931_lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Op codes, FSM states, access-size decode, misalign check and store masks.
package ysyx_22040931_lsu_pkg;

    localparam logic [2:0] ROP_NONE = 3'd0;
    localparam logic [2:0] ROP_LB   = 3'd1;
    localparam logic [2:0] ROP_LH   = 3'd2;
    localparam logic [2:0] ROP_LW   = 3'd3;
    localparam logic [2:0] ROP_LD   = 3'd4;
    localparam logic [2:0] ROP_LBU  = 3'd5;
    localparam logic [2:0] ROP_LHU  = 3'd6;
    localparam logic [2:0] ROP_LWU  = 3'd7;

    localparam logic [2:0] WOP_SB = 3'd1;
    localparam logic [2:0] WOP_SH = 3'd2;
    localparam logic [2:0] WOP_SW = 3'd3;
    localparam logic [2:0] WOP_SD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    // Unknown codes fall through to the doubleword variant.
    function automatic size_t rop_size(input logic [2:0] rop);
        case (rop)
            ROP_LB, ROP_LBU: return SZ_B;
            ROP_LH, ROP_LHU: return SZ_H;
            ROP_LW, ROP_LWU: return SZ_W;
            default:         return SZ_D;
        endcase
    endfunction

    function automatic size_t wop_size(input logic [2:0] wop);
        case (wop)
            WOP_SB:  return SZ_B;
            WOP_SH:  return SZ_H;
            WOP_SW:  return SZ_W;
            default: return SZ_D;
        endcase
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [2:0] off);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [7:0] store_mask(input size_t sz, input logic [2:0] off);
        case (sz)
            SZ_B:    return 8'h01 << off;
            SZ_H:    return 8'h03 << off;
            SZ_W:    return 8'h0F << off;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040931_load_ext.sv
// Load lane select and sign/zero extension.
// Picks the addressed bytes out of an aligned doubleword.
module ysyx_22040931_load_ext
    import ysyx_22040931_lsu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        off,
    input  logic [2:0]        rop,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] lane;

    always_comb begin
        lane = rdata >> {off, 3'b000};
        case (rop)
            ROP_LB:  data = {{(DATA_W-8){lane[7]}}, lane[7:0]};
            ROP_LH:  data = {{(DATA_W-16){lane[15]}}, lane[15:0]};
            ROP_LW:  data = {{(DATA_W-32){lane[31]}}, lane[31:0]};
            ROP_LBU: data = {{(DATA_W-8){1'b0}}, lane[7:0]};
            ROP_LHU: data = {{(DATA_W-16){1'b0}}, lane[15:0]};
            ROP_LWU: data = {{(DATA_W-32){1'b0}}, lane[31:0]};
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/ysyx_22040931_lsu.sv
// Memory-stage load/store unit: one bus transaction per request,
// one registered writeback pulse per instruction.
module ysyx_22040931_lsu
    import ysyx_22040931_lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int PC_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              w_ena_i,
    input  logic [4:0]        w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              mem_ena_i,
    input  logic              mem_wr_i,
    input  logic [2:0]        memrop_i,
    input  logic [2:0]        memwop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_wen,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [7:0]        dmem_wmask,
    input  logic              dmem_rsp_valid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_w_ena,
    output logic [4:0]        wb_w_addr,
    output logic [DATA_W-1:0] wb_w_data,
    output logic [PC_W-1:0]   wb_pc,
    output logic              misalign
);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [2:0]        off;
    size_t             sz;
    logic              mis;
    logic              go;
    logic [2:0]        r_rop;
    logic [2:0]        r_off;
    logic              r_w_ena;
    logic [4:0]        r_w_addr;
    logic [DATA_W-1:0] r_w_data;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] ext_data;

    assign in_ready       = (state == ST_IDLE);
    assign dmem_req_valid = (state == ST_REQ);
    assign accept         = in_valid && in_ready;
    assign off            = mem_addr_i[2:0];
    assign sz             = mem_wr_i ? wop_size(memwop_i) : rop_size(memrop_i);
    assign mis            = misaligned(sz, off);
    assign go             = accept && mem_ena_i && !mis;

    ysyx_22040931_load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .rdata (dmem_rdata),
        .off   (r_off),
        .rop   (r_rop),
        .data  (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Responses are only honoured in WAIT; a same-cycle grant+rsp in REQ drops the rsp.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (go) state_nxt = ST_REQ;
            ST_REQ:  if (dmem_req_ready) state_nxt = dmem_wen ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (dmem_rsp_valid) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_addr  <= '0;
            dmem_wen   <= 1'b0;
            dmem_wdata <= '0;
            dmem_wmask <= '0;
            r_rop      <= '0;
            r_off      <= '0;
            r_w_ena    <= 1'b0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
            r_pc       <= '0;
            wb_valid   <= 1'b0;
            wb_w_ena   <= 1'b0;
            wb_w_addr  <= '0;
            wb_w_data  <= '0;
            wb_pc      <= '0;
            misalign   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            if (accept && !mem_ena_i) begin
                wb_valid  <= 1'b1;
                wb_w_ena  <= w_ena_i;
                wb_w_addr <= w_addr_i;
                wb_w_data <= w_data_i;
                wb_pc     <= pc_i;
            end else if (accept && mis) begin
                wb_valid  <= 1'b1;
                misalign  <= 1'b1;
                wb_w_ena  <= 1'b0;
                wb_w_addr <= w_addr_i;
                wb_w_data <= '0;
                wb_pc     <= pc_i;
            end else if (go) begin
                dmem_addr  <= {mem_addr_i[ADDR_W-1:3], 3'b000};
                dmem_wen   <= mem_wr_i;
                dmem_wdata <= mem_data_i << {off, 3'b000};
                dmem_wmask <= mem_wr_i ? store_mask(sz, off) : 8'h00;
                r_rop      <= memrop_i;
                r_off      <= off;
                r_w_ena    <= w_ena_i;
                r_w_addr   <= w_addr_i;
                r_w_data   <= w_data_i;
                r_pc       <= pc_i;
            end
            if (state == ST_REQ && dmem_req_ready && dmem_wen) begin
                wb_valid  <= 1'b1;
                wb_w_ena  <= r_w_ena;
                wb_w_addr <= r_w_addr;
                wb_w_data <= r_w_data;
                wb_pc     <= r_pc;
            end
            if (state == ST_WAIT && dmem_rsp_valid) begin
                wb_valid  <= 1'b1;
                wb_w_ena  <= r_w_ena;
                wb_w_addr <= r_w_addr;
                wb_w_data <= ext_data;
                wb_pc     <= r_pc;
            end
        end
    end

endmodule
